// File: rtl/i2c_accel_target.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module  : i2c_accel_target
// Brief   : I2C target exposing the latest accelerometer sample, a WHO_AM_I
//           byte, a sticky NEW flag and a host-writable CTRL byte through an
//           8-bit auto-incrementing register pointer. No clock stretching.
// Revision: 1.0 - initial release
// ============================================================================
module i2c_accel_target #(
  parameter logic [6:0] DEV_ADDR = 7'h1D,
  parameter logic [7:0] WHO_AM_I = 8'hA5
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        SCL_IN,
  input  logic        SDA_IN,
  output logic        SDA_OE,
  input  logic [11:0] AccelX,
  input  logic [11:0] AccelY,
  input  logic [11:0] AccelZ,
  input  logic        DataValid,
  output logic [7:0]  CTRL,
  output logic        BUSY
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_REG       = 4'd3;
  localparam logic [3:0] S_REG_ACK   = 4'd4;
  localparam logic [3:0] S_WRITE     = 4'd5;
  localparam logic [3:0] S_WRITE_ACK = 4'd6;
  localparam logic [3:0] S_READ      = 4'd7;
  localparam logic [3:0] S_READ_ACK  = 4'd8;

  logic [2:0]  scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [3:0]  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d, ptr_q, ptr_d, ctrl_q, ctrl_d;
  logic        rw_q, rw_d, phase_q, phase_d, new_q, new_d;
  logic        sda_oe_q, sda_oe_d;
  logic [11:0] hold_x_q, hold_x_d, hold_y_q, hold_y_d, hold_z_q, hold_z_d;
  logic [11:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d, sh_z_q, sh_z_d;

  logic       scl_rise, scl_fall, start_det, stop_det, sda_bit, snap;
  logic [7:0] shift_in, rd_byte;

  // Bus events from the synchronized pads (stage 1 = current, stage 2 = previous)
  assign sda_bit   = sda_sync_q[1];
  assign scl_rise  =  scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall  = ~scl_sync_q[1] &  scl_sync_q[2];
  assign start_det =  scl_sync_q[1] &  scl_sync_q[2] & ~sda_sync_q[1] &  sda_sync_q[2];
  assign stop_det  =  scl_sync_q[1] &  scl_sync_q[2] &  sda_sync_q[1] & ~sda_sync_q[2];
  assign shift_in  = {shift_q[6:0], sda_bit};

  assign SDA_OE = sda_oe_q;
  assign CTRL   = ctrl_q;

  // State register and all datapath flops; lines idle high out of reset
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      ptr_q      <= 8'h00;
      ctrl_q     <= 8'h00;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      new_q      <= 1'b0;
      sda_oe_q   <= 1'b0;
      hold_x_q   <= 12'h000;
      hold_y_q   <= 12'h000;
      hold_z_q   <= 12'h000;
      sh_x_q     <= 12'h000;
      sh_y_q     <= 12'h000;
      sh_z_q     <= 12'h000;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      ctrl_q     <= ctrl_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      new_q      <= new_d;
      sda_oe_q   <= sda_oe_d;
      hold_x_q   <= hold_x_d;
      hold_y_q   <= hold_y_d;
      hold_z_q   <= hold_z_d;
      sh_x_q     <= sh_x_d;
      sh_y_q     <= sh_y_d;
      sh_z_q     <= sh_z_d;
    end
  end

  // Next-state: protocol sequencing, pointer/CTRL updates, sample and snapshot
  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], SCL_IN};
    sda_sync_d = {sda_sync_q[1:0], SDA_IN};
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    ctrl_d     = ctrl_q;
    rw_d       = rw_q;
    phase_d    = phase_q;
    new_d      = new_q;
    hold_x_d   = hold_x_q;
    hold_y_d   = hold_y_q;
    hold_z_d   = hold_z_q;
    sh_x_d     = sh_x_q;
    sh_y_d     = sh_y_q;
    sh_z_d     = sh_z_q;
    snap       = 1'b0;

    if (stop_det) begin
      state_d = S_IDLE;
    end else if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = 3'd0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (shift_in[7:1] == DEV_ADDR) begin
              state_d = S_ADDR_ACK;
              rw_d    = shift_in[0];
              phase_d = 1'b0;
              snap    = shift_in[0];
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_REG, S_WRITE: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            phase_d = 1'b0;
            if (state_q == S_REG) begin
              state_d = S_REG_ACK;
              ptr_d   = shift_in;
            end else begin
              state_d = S_WRITE_ACK;
            end
          end
        end
        // phase 0: waiting for the fall after bit 8; phase 1: driving ACK
        S_ADDR_ACK, S_REG_ACK, S_WRITE_ACK: if (scl_fall) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            if (state_q == S_WRITE_ACK) begin
              if (ptr_q == 8'h08) ctrl_d = shift_q;
              ptr_d = ptr_q + 8'd1;
            end
          end else begin
            phase_d   = 1'b0;
            bit_cnt_d = 3'd0;
            if (state_q == S_ADDR_ACK) state_d = rw_q ? S_READ : S_REG;
            else                       state_d = S_WRITE;
          end
        end
        S_READ: if (scl_fall) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_READ_ACK;
            phase_d = 1'b0;
          end
        end
        // phase 0: waiting for the host ACK bit; phase 1: ACKed, await fall
        S_READ_ACK: begin
          if (scl_rise && !phase_q) begin
            ptr_d = ptr_q + 8'd1;
            if (sda_bit) state_d = S_IDLE;
            else         phase_d = 1'b1;
          end else if (scl_fall && phase_q) begin
            state_d   = S_READ;
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // Snapshot takes the pre-update holding values; a same-cycle sample wins NEW
    if (snap) begin
      sh_x_d = hold_x_q;
      sh_y_d = hold_y_q;
      sh_z_d = hold_z_q;
      new_d  = 1'b0;
    end
    if (DataValid) begin
      hold_x_d = AccelX;
      hold_y_d = AccelY;
      hold_z_d = AccelZ;
      new_d    = 1'b1;
    end
  end

  // Outputs: register-map read mux, SDA pull-down request and BUSY
  always_comb begin
    case (ptr_q)
      8'h00:   rd_byte = WHO_AM_I;
      8'h01:   rd_byte = sh_x_q[7:0];
      8'h02:   rd_byte = {4'b0000, sh_x_q[11:8]};
      8'h03:   rd_byte = sh_y_q[7:0];
      8'h04:   rd_byte = {4'b0000, sh_y_q[11:8]};
      8'h05:   rd_byte = sh_z_q[7:0];
      8'h06:   rd_byte = {4'b0000, sh_z_q[11:8]};
      8'h07:   rd_byte = {7'b0000000, new_q};
      8'h08:   rd_byte = ctrl_q;
      default: rd_byte = 8'h00;
    endcase
    sda_oe_d = 1'b0;
    case (state_q)
      S_ADDR_ACK, S_REG_ACK, S_WRITE_ACK: sda_oe_d = phase_q;
      S_READ:                             sda_oe_d = ~rd_byte[~bit_cnt_q];
      default:                            sda_oe_d = 1'b0;
    endcase
    BUSY = (state_q != S_IDLE) && (state_q != S_ADDR);
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_accel_target.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module  : tb_i2c_accel_target
// Brief   : Self-checking bench; a bit-banged I2C host over an open-drain SDA
//           model, a register-read vector table and hand-written corner cases.
// Revision: 1.0 - initial release
// ============================================================================
module tb_i2c_accel_target;

  localparam int Q = 8;  // quarter SCL period in CLOCK_50 cycles

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_pad = 1'b1;
  logic        host_low = 1'b0;
  logic        sda_oe;
  logic        sda_line;
  logic [11:0] ax = '0, ay = '0, az = '0;
  logic        dv = 1'b0;
  logic [7:0]  ctrl;
  logic        busy;
  logic        mon_en = 1'b0;
  int          oe_cnt = 0, busy_cnt = 0;
  int          n_checks = 0, n_fail = 0;

  assign sda_line = ~(host_low | sda_oe);

  i2c_accel_target dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .SCL_IN   (scl_pad),
    .SDA_IN   (sda_line),
    .SDA_OE   (sda_oe),
    .AccelX   (ax),
    .AccelY   (ay),
    .AccelZ   (az),
    .DataValid(dv),
    .CTRL     (ctrl),
    .BUSY     (busy)
  );

  always #10 clk = ~clk;

  // Activity monitor for the wrong-address and post-reset windows
  always @(negedge clk) begin
    if (mon_en) begin
      if (sda_oe === 1'b1) oe_cnt = oe_cnt + 1;
      if (busy === 1'b1) busy_cnt = busy_cnt + 1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    host_low = 1'b0; wq();
    scl_pad  = 1'b1; wq();
    host_low = 1'b1; wq();
    scl_pad  = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    host_low = 1'b1; wq();
    scl_pad  = 1'b1; wq();
    host_low = 1'b0; wq();
  endtask

  task automatic send_bit(input logic b, output logic s);
    host_low = ~b;   wq();
    scl_pad  = 1'b1; wq();
    s = sda_line;    wq();
    scl_pad  = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    send_bit(~ack, s);
  endtask

  // Pointer write, repeated START, single-byte read with NACK, STOP
  task automatic rd_reg(input logic [7:0] p, output logic [7:0] d, output logic ok);
    logic a1, a2, a3;
    i2c_start(); write_byte(8'h3A, a1); write_byte(p, a2);
    i2c_start(); write_byte(8'h3B, a3); read_byte(1'b0, d);
    i2c_stop();
    ok = a1 & a2 & a3;
  endtask

  task automatic wr_reg(input logic [7:0] p, input logic [7:0] v, output logic ok);
    logic a1, a2, a3;
    i2c_start(); write_byte(8'h3A, a1); write_byte(p, a2); write_byte(v, a3);
    i2c_stop();
    ok = a1 & a2 & a3;
  endtask

  task automatic pulse(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
    @(negedge clk);
    ax = x; ay = y; az = z; dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
  endtask

  initial begin
    vec_t       tbl [12];
    logic [7:0] exp_burst [7] = '{8'hBC, 8'h0A, 8'h23, 8'h01, 8'hFF, 8'h0F, 8'h01};
    logic [7:0] d;
    logic       a1, a2, a3, ok, s;
    int         oe0, busy0;

    tbl[0]  = '{8'h00, 8'hA5};  tbl[1]  = '{8'h01, 8'h21};
    tbl[2]  = '{8'h02, 8'h03};  tbl[3]  = '{8'h03, 8'h54};
    tbl[4]  = '{8'h04, 8'h06};  tbl[5]  = '{8'h05, 8'h87};
    tbl[6]  = '{8'h06, 8'h09};  tbl[7]  = '{8'h07, 8'h00};
    tbl[8]  = '{8'h08, 8'h5C};  tbl[9]  = '{8'h09, 8'h00};
    tbl[10] = '{8'h80, 8'h00};  tbl[11] = '{8'hFF, 8'h00};

    repeat (5) @(negedge clk);
    check("reset_sda_oe", sda_oe, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_ctrl", ctrl, 8'h00);
    rst = 1'b0;
    wq();

    // ID read
    i2c_start(); write_byte(8'h3A, a1);
    check("busy_after_addr", busy, 1'b1);
    write_byte(8'h00, a2);
    i2c_start(); write_byte(8'h3B, a3); read_byte(1'b0, d); i2c_stop();
    check("id_ack_addr_w", a1, 1'b1);
    check("id_ack_ptr", a2, 1'b1);
    check("id_ack_addr_r", a3, 1'b1);
    check("id_byte", d, 8'hA5);
    check("busy_after_stop", busy, 1'b0);

    // Burst read with a new sample arriving mid-burst
    pulse(12'hABC, 12'h123, 12'hFFF);
    i2c_start(); write_byte(8'h3A, a1); write_byte(8'h01, a2);
    i2c_start(); write_byte(8'h3B, a3);
    check("burst_acks", {a1, a2, a3}, 3'b111);
    for (int i = 0; i < 7; i++) begin
      read_byte(i != 6, d);
      check($sformatf("burst_byte%0d", i), d, exp_burst[i]);
      if (i == 2) pulse(12'h456, 12'h789, 12'h0AA);
    end
    i2c_stop();
    rd_reg(8'h01, d, ok);
    check("burst_next_x_lo", d, 8'h56);

    // CTRL write, pointer increment, readback
    wr_reg(8'h08, 8'h5C, ok);
    check("ctrl_wr_acks", ok, 1'b1);
    check("ctrl_value", ctrl, 8'h5C);
    i2c_start(); write_byte(8'h3B, a1); read_byte(1'b0, d); i2c_stop();
    check("ptr_after_write_reads_09", d, 8'h00);
    rd_reg(8'h08, d, ok);
    check("ctrl_readback", d, 8'h5C);
    wr_reg(8'h00, 8'h77, ok);
    rd_reg(8'h00, d, ok);
    check("ro_write_ignored", d, 8'hA5);

    // Register map table
    pulse(12'h321, 12'h654, 12'h987);
    for (int i = 0; i < 12; i++) begin
      rd_reg(tbl[i].ptr, d, ok);
      check($sformatf("tbl_acks_%02h", tbl[i].ptr), ok, 1'b1);
      check($sformatf("tbl_reg_%02h", tbl[i].ptr), d, tbl[i].exp);
    end

    // Wrong address
    oe0 = oe_cnt; busy0 = busy_cnt; mon_en = 1'b1;
    i2c_start(); write_byte(8'h40, a1); write_byte(8'h00, a2); i2c_stop();
    mon_en = 1'b0;
    check("wrong_addr_ack", a1, 1'b0);
    check("wrong_addr_sda_oe", oe_cnt - oe0, 0);
    check("wrong_addr_busy", busy_cnt - busy0, 0);

    // Pointer wrap
    i2c_start(); write_byte(8'h3A, a1); write_byte(8'hFF, a2);
    i2c_start(); write_byte(8'h3B, a3);
    read_byte(1'b1, d); check("wrap_byte_ff", d, 8'h00);
    read_byte(1'b0, d); check("wrap_byte_00", d, 8'hA5);
    i2c_stop();

    // RESET mid-READ of 0xA5: bit 6 is 0, so SDA is pulled after the first bit
    i2c_start(); write_byte(8'h3A, a1); write_byte(8'h00, a2);
    i2c_start(); write_byte(8'h3B, a3);
    send_bit(1'b1, s);
    check("abort_first_bit", s, 1'b1);
    check("abort_oe_driving", sda_oe, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_oe_released", sda_oe, 1'b0);
    check("abort_ctrl_reset", ctrl, 8'h00);
    rst = 1'b0;
    oe0 = oe_cnt; busy0 = busy_cnt; mon_en = 1'b1;
    for (int i = 0; i < 4; i++) send_bit(i[0], s);
    mon_en = 1'b0;
    check("post_reset_ignored_oe", oe_cnt - oe0, 0);
    check("post_reset_ignored_busy", busy_cnt - busy0, 0);
    i2c_stop();

    // STOP mid-WRITE discards the partial byte and leaves the pointer
    wr_reg(8'h08, 8'h5C, ok);
    check("ctrl_rewrite", ctrl, 8'h5C);
    i2c_start(); write_byte(8'h3A, a1); write_byte(8'h08, a2);
    for (int i = 0; i < 4; i++) send_bit(i[0], s);
    i2c_stop();
    check("partial_write_discarded", ctrl, 8'h5C);
    i2c_start(); write_byte(8'h3B, a1); read_byte(1'b0, d); i2c_stop();
    check("partial_write_ptr_kept", d, 8'h5C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
